// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer and tick prescaler for the stopwatch BCD digit chain.
// Drives the chain's enable, direction, clear and preset-load controls.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIVISOR  = 1000000,
    parameter int unsigned PRESCALE_BITS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic start_stop,
    input  logic clear,
    input  logic mode_down,
    input  logic at_zero,
    output logic count_en,
    output logic up_down,
    output logic digits_clr,
    output logic digits_load,
    output logic running,
    output logic alarm
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [PRESCALE_BITS-1:0] PRESC_TERM = PRESCALE_BITS'(TICK_DIVISOR - 1);
    localparam logic [PRESCALE_BITS-1:0] PRESC_ONE  = PRESCALE_BITS'(1);

    logic [1:0]               state_q;
    logic [1:0]               state_d;
    logic [PRESCALE_BITS-1:0] presc_q;
    logic [PRESCALE_BITS-1:0] presc_d;
    logic                     dir_down_q;
    logic                     dir_down_d;
    logic                     count_en_d;
    logic                     digits_clr_d;
    logic                     digits_load_d;
    logic                     advance;

    // Next-state logic. A cycle that ends in RUN (staying or entering) advances
    // the prescaler, so count_en lands registered on the cycle after terminal count.
    always_comb begin
        state_d       = state_q;
        presc_d       = presc_q;
        dir_down_d    = dir_down_q;
        count_en_d    = 1'b0;
        digits_clr_d  = 1'b0;
        digits_load_d = 1'b0;
        advance       = 1'b0;

        if (state_q == S_IDLE) begin
            dir_down_d = mode_down;
        end

        if (clear) begin
            state_d       = S_IDLE;
            presc_d       = '0;
            digits_clr_d  = ~dir_down_d;
            digits_load_d = dir_down_d;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_stop) begin
                        if (dir_down_q && at_zero) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RUN;
                            advance = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (dir_down_q && at_zero) begin
                        state_d = S_DONE;
                    end else if (start_stop) begin
                        state_d = S_PAUSE;
                    end else begin
                        advance = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (start_stop) begin
                        state_d = S_RUN;
                        advance = 1'b1;
                    end
                end
                default: begin
                    state_d = S_DONE;
                end
            endcase
        end

        if (advance) begin
            if (presc_q == PRESC_TERM) begin
                count_en_d = 1'b1;
                presc_d    = '0;
            end else begin
                presc_d    = presc_q + PRESC_ONE;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            dir_down_q  <= 1'b0;
            count_en    <= 1'b0;
            digits_clr  <= 1'b0;
            digits_load <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            dir_down_q  <= dir_down_d;
            count_en    <= count_en_d;
            digits_clr  <= digits_clr_d;
            digits_load <= digits_load_d;
        end
    end

    assign up_down = ~dir_down_q;
    assign running = (state_q == S_RUN);
    assign alarm   = (state_q == S_DONE);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIVISOR = 4; cycle k is the interval after the k-th clock edge.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start_stop;
    logic clear;
    logic mode_down;
    logic at_zero;
    logic count_en;
    logic up_down;
    logic digits_clr;
    logic digits_load;
    logic running;
    logic alarm;

    int cyc;
    int n_assert;
    int n_fail;

    stopwatch_ctrl #(
        .TICK_DIVISOR (4),
        .PRESCALE_BITS(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .mode_down  (mode_down),
        .at_zero    (at_zero),
        .count_en   (count_en),
        .up_down    (up_down),
        .digits_clr (digits_clr),
        .digits_load(digits_load),
        .running    (running),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected vector order: {running, count_en, alarm, up_down, digits_clr, digits_load}
    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] got;
        got = {running, count_en, alarm, up_down, digits_clr, digits_load};
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=%b exp=%b (run,en,alarm,up,clr,load)", tag, cyc, got, exp);
        end
    endtask

    task automatic do_reset();
        cyc        = 0;
        rst        = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        mode_down  = 1'b0;
        at_zero    = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;

        // Reset then up run: start at 10, ticks at 14, 18, 22
        do_reset();
        check("reset_state", 6'b000100);
        while (cyc <= 24) begin
            check("up_run", {1'(cyc >= 11), 1'(cyc == 14 || cyc == 18 || cyc == 22),
                             1'b0, 1'b1, 1'b0, 1'b0});
            start_stop = (cyc == 10);
            step();
        end

        // Pause at 16 with prescaler at 2, resume at 30, next ticks 32 and 36
        do_reset();
        while (cyc <= 37) begin
            check("pause_resume", {1'((cyc >= 11 && cyc <= 16) || cyc >= 31),
                                   1'(cyc == 14 || cyc == 32 || cyc == 36),
                                   1'b0, 1'b1, 1'b0, 1'b0});
            start_stop = (cyc == 10 || cyc == 16 || cyc == 30);
            step();
        end

        // Countdown: load at 6, tick at 14, at_zero on terminal cycle 17 stops with alarm
        do_reset();
        mode_down = 1'b1;
        while (cyc <= 24) begin
            check("countdown", {1'(cyc >= 11 && cyc <= 17), 1'(cyc == 14), 1'(cyc >= 18),
                                1'(cyc <= 2), 1'b0, 1'(cyc == 6)});
            clear      = (cyc == 5);
            start_stop = (cyc == 10 || cyc == 20);
            at_zero    = (cyc >= 17);
            step();
        end

        // Preset already zero: straight to DONE; clear from DONE and again in IDLE
        do_reset();
        mode_down = 1'b1;
        at_zero   = 1'b1;
        while (cyc <= 12) begin
            check("preset_zero", {1'b0, 1'b0, 1'(cyc >= 6 && cyc <= 8), 1'(cyc <= 2),
                                  1'b0, 1'(cyc == 9 || cyc == 11)});
            start_stop = (cyc == 5);
            clear      = (cyc == 8 || cyc == 10);
            step();
        end

        // Clear and start_stop together on a terminal-count cycle during up run
        do_reset();
        while (cyc <= 20) begin
            check("clear_prio", {1'(cyc >= 6 && cyc <= 12), 1'(cyc == 9), 1'b0, 1'b1,
                                 1'(cyc == 13), 1'b0});
            start_stop = (cyc == 5 || cyc == 12);
            clear      = (cyc == 12);
            step();
        end

        // Direction frozen in RUN; new mode only captured after clear returns to IDLE
        do_reset();
        while (cyc <= 14) begin
            check("mode_freeze", {1'(cyc >= 5 && cyc <= 10), 1'(cyc == 8), 1'b0,
                                  1'(cyc <= 11), 1'(cyc == 11), 1'b0});
            start_stop = (cyc == 4);
            mode_down  = (cyc >= 6);
            clear      = (cyc == 10);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
